// File: rtl/ram_2x8_fifo_ctrl_pkg.sv
// Shared constants and the access-op enum used by the RAM
// FIFO controller, its arbiter, and the bench.
package ram_2x8_pkg;

    localparam int DATA_W    = 8;
    localparam int RAM_DEPTH = 2;
    localparam int PTR_W     = $clog2(RAM_DEPTH);
    localparam int CNT_W     = $clog2(RAM_DEPTH + 1);

    typedef enum logic [1:0] {
        OP_NONE,
        OP_WRITE,
        OP_READ
    } op_e;

    function automatic logic [PTR_W-1:0] ptr_next(
        input logic [PTR_W-1:0] p
    );
        return p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/ram_2x8_fifo_ctrl_if.sv
// Stream-in, stream-out and RAM-port bundle for the
// 2x8 RAM FIFO controller.
interface ram_2x8_fifo_ctrl_if
    import ram_2x8_pkg::*;
#(
    parameter int DATA_W = ram_2x8_pkg::DATA_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    logic              ram_enable;
    logic              ram_write_enable;
    logic [PTR_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_dados_in;
    logic [DATA_W-1:0] ram_dados_out;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output ram_enable,
        output ram_write_enable,
        output ram_addr,
        output ram_dados_in,
        input  ram_dados_out
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  ram_enable,
        input  ram_write_enable,
        input  ram_addr,
        input  ram_dados_in,
        output ram_dados_out
    );

endinterface

// File: rtl/ram_2x8_arbiter.sv
// Round-robin write/read arbiter for the single RAM port;
// on a tie the op opposite to the last grant wins.
module ram_2x8_arbiter
    import ram_2x8_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic read_req,
    input  logic write_req,
    output op_e  grant
);

    op_e last_op_q;
    op_e last_op_d;

    always_comb begin
        grant = OP_NONE;
        unique case (1'b1)
            (write_req && read_req):
                grant = (last_op_q == OP_WRITE) ? OP_READ
                                                : OP_WRITE;
            (write_req && !read_req):
                grant = OP_WRITE;
            (read_req && !write_req):
                grant = OP_READ;
            default:
                grant = OP_NONE;
        endcase
    end

    always_comb begin
        last_op_d = last_op_q;
        if (grant != OP_NONE) begin
            last_op_d = grant;
        end
    end

    // READ after reset so that a write wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_op_q <= OP_READ;
        end else begin
            last_op_q <= last_op_d;
        end
    end

endmodule

// File: rtl/ram_2x8_fifo_ctrl.sv
// Two-entry circular FIFO over a single-port 2x8 RAM with
// a registered output stage; one RAM access per cycle.
module ram_2x8_fifo_ctrl #(
    parameter int DATA_W = ram_2x8_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ram_2x8_fifo_ctrl_if.slave   bus
);

    import ram_2x8_pkg::*;

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;

    logic              read_req;
    logic              write_req;
    op_e               grant;

    logic              ram_en;
    logic              ram_we;
    logic [PTR_W-1:0]  ram_addr;
    logic              in_rdy;

    // rst_n gating keeps every strobe low while reset is held
    always_comb begin
        read_req  = rst_n
                 && (count_q != '0)
                 && (!out_valid_q || bus.out_ready);
        write_req = rst_n
                 && bus.in_valid
                 && (count_q != CNT_W'(RAM_DEPTH));
    end

    ram_2x8_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .read_req  (read_req),
        .write_req (write_req),
        .grant     (grant)
    );

    always_comb begin
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        in_rdy      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (grant)
            OP_WRITE: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = wr_ptr_q;
                in_rdy   = 1'b1;
                wr_ptr_d = ptr_next(wr_ptr_q);
                count_d  = count_q + CNT_W'(1);
            end
            OP_READ: begin
                ram_en      = 1'b1;
                ram_addr    = rd_ptr_q;
                rd_ptr_d    = ptr_next(rd_ptr_q);
                count_d     = count_q - CNT_W'(1);
                out_valid_d = 1'b1;
                out_data_d  = bus.ram_dados_out;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.ram_enable       = ram_en;
    assign bus.ram_write_enable = ram_we;
    assign bus.ram_addr         = ram_addr;
    assign bus.ram_dados_in     = bus.in_data;
    assign bus.in_ready         = in_rdy;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_data         = out_data_q;

endmodule

// File: tb/tb_ram_2x8_fifo_ctrl.sv
// Bench for ram_2x8_fifo_ctrl: directed scenarios then random
// traffic, checked against a queue-based reference model.
module tb_ram_2x8_fifo_ctrl;

    import ram_2x8_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ram_2x8_fifo_ctrl_if #(.DATA_W(DATA_W)) bus();

    ram_2x8_fifo_ctrl #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural single-port RAM beside the controller
    logic [DATA_W-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (bus.ram_enable && bus.ram_write_enable) begin
            mem[bus.ram_addr] <= bus.ram_dados_in;
        end
    end

    assign bus.ram_dados_out = mem[bus.ram_addr];

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] fq [$];
    int         wr_n;
    int         rd_n;
    logic       m_valid;
    logic [7:0] m_data;
    logic       last_w;
    logic       acc;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        wr_n    = 0;
        rd_n    = 0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        last_w  = 1'b0;
    endtask

    task automatic step(input logic v,
                        input logic [7:0] d,
                        input logic r);
        logic rreq;
        logic wreq;
        op_e  g;
        int   ea;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        rreq = (fq.size() != 0) && (!m_valid || r);
        wreq = v && (fq.size() < RAM_DEPTH);
        if (wreq && (!rreq || !last_w)) g = OP_WRITE;
        else if (rreq)                  g = OP_READ;
        else                            g = OP_NONE;
        ea = (g == OP_WRITE) ? (wr_n % RAM_DEPTH) :
             (g == OP_READ)  ? (rd_n % RAM_DEPTH) : 0;
        chk("in_ready", 32'(bus.in_ready), 32'(g == OP_WRITE));
        chk("ram_en", 32'(bus.ram_enable), 32'(g != OP_NONE));
        chk("ram_we", 32'(bus.ram_write_enable),
            32'(g == OP_WRITE));
        chk("ram_addr", 32'(bus.ram_addr), 32'(ea));
        if (g == OP_WRITE) begin
            chk("ram_din", 32'(bus.ram_dados_in), 32'(d));
        end
        acc = (g == OP_WRITE);
        @(posedge clk);
        if (m_valid && r) m_valid = 1'b0;
        if (g == OP_READ) begin
            m_data  = fq.pop_front();
            m_valid = 1'b1;
            rd_n++;
            last_w  = 1'b0;
        end
        if (g == OP_WRITE) begin
            fq.push_back(d);
            wr_n++;
            last_w = 1'b1;
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_data", 32'(bus.out_data), 32'(m_data));
    endtask

    task automatic push(input logic [7:0] d, input logic r);
        int k;
        k = 0;
        do begin
            step(1'b1, d, r);
            k++;
        end while (!acc && k < 8);
        chk("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_en"}, 32'(bus.ram_enable), 32'd0);
        chk({tag, "_we"}, 32'(bus.ram_write_enable), 32'd0);
        chk({tag, "_addr"}, 32'(bus.ram_addr), 32'd0);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_ov"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_od"}, 32'(bus.out_data), 32'd0);
    endtask

    initial begin
        int rd0;
        int j;
        model_reset();
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h55;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single byte, latency two cycles
        step(1'b1, 8'hA5, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_data", 32'(bus.out_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1);
        chk("single_drained", 32'(bus.out_valid), 32'd0);

        // fill under backpressure
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        chk("full_rdy", 32'(bus.in_ready), 32'd0);
        chk("full_hold", 32'(bus.out_data), 32'h11);
        chk("full_valid", 32'(bus.out_valid), 32'd1);

        // drain in order with pointer wrap
        push(8'h44, 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        chk("drain_last", 32'(bus.out_data), 32'h44);

        // simultaneous requests over a stream
        rd0 = rd_n;
        j   = 1;
        for (int c = 0; c < 40 && (rd_n - rd0) < 8; c++) begin
            step(j <= 8, 8'(j), 1'b1);
            if (acc) j++;
        end
        chk("stream_reads", 32'(rd_n - rd0), 32'd8);
        chk("stream_last", 32'(bus.out_data), 32'h08);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // consume and reload at the same edge
        push(8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        push(8'h6B, 1'b0);
        chk("cr_pre", 32'(bus.out_data), 32'h5A);
        step(1'b0, 8'h00, 1'b1);
        chk("cr_valid", 32'(bus.out_valid), 32'd1);
        chk("cr_data", 32'(bus.out_data), 32'h6B);

        // asynchronous reset with a full buffer
        push(8'h77, 1'b0);
        push(8'h88, 1'b0);
        bus.in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        model_reset();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_en", 32'(bus.ram_enable), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(8'hC3, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("rst_first_v", 32'(bus.out_valid), 32'd1);
        chk("rst_first_d", 32'(bus.out_data), 32'hC3);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            step(($urandom % 4) != 0,
                 8'($urandom),
                 ($urandom % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_2x8_fifo_ctrl.md
# ram_2x8_fifo_ctrl

Access controller directly upstream of the 2x8 byte RAM: accepts a byte stream on a valid/ready input port and buffers it in the RAM's two locations as a 2-entry circular FIFO. It also reads bytes back into a registered output stage with its own valid/ready handshake. The RAM is single-port, so this block arbitrates between writes and reads, with at most one RAM access per cycle. Total buffering is 3 bytes: 2 in RAM plus 1 in the output register.

## Interface
- DATA_W, default 8: byte width; must match the RAM data width.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  byte offered by the upstream producer.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  byte is accepted this cycle; combinational, high only when a write is granted.
- out_data  output  DATA_W  registered output byte.
- out_valid  output  1  out_data holds an unconsumed byte.
- out_ready  input  1  downstream consumes out_data this cycle.
- ram_enable  output  1  RAM access strobe; combinational.
- ram_write_enable  output  1  1 = write, 0 = read; combinational.
- ram_addr  output  1  RAM location, 0 or 1.
- ram_dados_in  output  DATA_W  write data; driven equal to in_data.
- ram_dados_out  input  DATA_W  RAM read data; valid in the same cycle as a read access.

## Operation
- State:
  - wr_ptr, rd_ptr: 1 bit each, toggle on use; wrap 1→0 is implicit.
  - count: 2 bits, range 0..2.
  - out_valid, out_data.
  - last_op: WRITE or READ; the round-robin arbiter state.
- Per-cycle requests, evaluated from registered state:
  - read_req = (count != 0) && (!out_valid || out_ready).
  - write_req = in_valid && (count != 2).
- Grant:
  - Only one request: that request wins.
  - Both requests: the op opposite to last_op wins.
  - last_op updates to the granted op; it holds when nothing is granted.
- Write grant:
  - Drive ram_enable=1, ram_write_enable=1, ram_addr=wr_ptr, in_ready=1.
  - At the edge: wr_ptr toggles, count+1.
- Read grant:
  - Drive ram_enable=1, ram_write_enable=0, ram_addr=rd_ptr.
  - At the edge: out_data←ram_dados_out, out_valid←1, rd_ptr toggles, count−1.
- No grant: ram_enable=0, ram_write_enable=0, ram_addr=0, in_ready=0.
- Output handshake:
  - out_valid && out_ready with no read grant → out_valid←0 and out_data holds.
  - Consume and reload in the same cycle → out_valid stays 1 with the new byte.
- count never changes by 2 in one cycle, because only one access is made per cycle.
- in_ready never depends on out_ready except through arbitration.
- Reset (rst_n low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, out_valid=0, out_data=0, last_op=READ (so a write wins the first tie).
  - While rst_n is low, all combinational outputs are forced to 0 (ram_enable, ram_write_enable, ram_addr, in_ready).
  - Reset mid-stream discards all buffered bytes. No RAM access is issued during reset.

## Timing
- Latency: a byte accepted at edge E (write) is read at the earliest at edge E+1 and is visible on out_data/out_valid after E+1. Minimum latency is 2 cycles from in_valid to out_valid.
- Throughput: 1 byte per cycle in bursts until the RAM is full. Sustained with a continuously ready consumer: 1 byte per 2 cycles, from strict write/read alternation.
- Full (count=2): in_ready=0 regardless of in_valid. The next read frees a slot; a write can be granted the cycle after that read.
- Empty (count=0) with out_valid=0: out_valid stays 0. Bytes are never bypassed from in_data to out_data.
- Backpressure: out_valid=1 && !out_ready blocks reads. Up to 2 further bytes are accepted, then in_ready drops.
- Producer may change in_data whenever in_ready=0. No requirement is placed on in_valid stability.

## Structure
- Shared package ram_2x8_pkg holds:
  - DATA_W=8 and RAM_DEPTH=2.
  - An op enum {OP_NONE, OP_WRITE, OP_READ} used by the controller and the bench.
- One natural sub-module: ram_2x8_arbiter. Inputs read_req, write_req, last_op; outputs grant. Purely combinational, plus the last_op register.
- The top-level controller instantiates the arbiter. The RAM itself is instantiated beside the controller, not inside it.

## Test plan
- Reset then single byte:
  - Stimulus: in_valid with 0xA5 for one cycle, out_ready=1.
  - Required: write to addr 0; out_data=0xA5 with out_valid=1 two cycles after acceptance; count returns to 0.
- Fill under backpressure:
  - Stimulus: out_ready=0, push 0x11, 0x22, 0x33, 0x44.
  - Required: 0x11, 0x22, 0x33 accepted; 0x44 sees in_ready=0 while out_valid=1 holds 0x11 and count=2.
- Drain order and wrap:
  - Stimulus: from the previous state, raise out_ready.
  - Required: output sequence 0x11, 0x22, 0x33; rd_ptr wraps 1→0; 0x44 is accepted after the first read slot frees.
- Simultaneous requests:
  - Stimulus: continuous in_valid and out_ready over a stream 0x01..0x08.
  - Required: grants alternate WRITE/READ each cycle; output order 0x01..0x08 with no loss or duplication.
- Consume and reload:
  - Stimulus: out_valid=1 with 0x5A, count=1 holding 0x6B, out_ready=1.
  - Required: out_valid stays 1 and out_data becomes 0x6B at the same edge.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously with count=2 and out_valid=1.
  - Required: outputs zero immediately and no RAM access; after release, the first pushed byte 0xC3 is the first byte output.
